msrv32_ahb_data_arbiter: RTL and testbench

//  Two-requester arbiter/sequencer for the msrv32 AHB-Lite data port.

---
 rtl/msrv32_ahb_data_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_msrv32_ahb_data_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_ahb_data_arbiter.sv
// Two-port round-robin arbiter/sequencer for the msrv32 AHB-Lite data port.
// Optional data-phase timeout: define MSRV32_DARB_TIMEOUT_EN.
module msrv32_ahb_data_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                ms_riscv32_mp_clk_in,
    input  logic                ms_riscv32_mp_rst_in,
    input  logic                req0_valid_in,
    input  logic [ADDR_W-1:0]   req0_addr_in,
    input  logic [DATA_W-1:0]   req0_wdata_in,
    input  logic [DATA_W/8-1:0] req0_wmask_in,
    input  logic                req0_we_in,
    output logic                req0_ready_out,
    output logic                rsp0_valid_out,
    output logic [DATA_W-1:0]   rsp0_rdata_out,
    output logic                rsp0_err_out,
    input  logic                req1_valid_in,
    input  logic [ADDR_W-1:0]   req1_addr_in,
    input  logic [DATA_W-1:0]   req1_wdata_in,
    input  logic [DATA_W/8-1:0] req1_wmask_in,
    input  logic                req1_we_in,
    output logic                req1_ready_out,
    output logic                rsp1_valid_out,
    output logic [DATA_W-1:0]   rsp1_rdata_out,
    output logic                rsp1_err_out,
    output logic [ADDR_W-1:0]   ms_riscv32_mp_dmaddr_out,
    output logic [DATA_W-1:0]   ms_riscv32_mp_dmdata_out,
    output logic [DATA_W/8-1:0] ms_riscv32_mp_dmwr_mask_out,
    output logic                ms_riscv32_mp_dmwr_req_out,
    output logic [1:0]          ms_riscv32_mp_data_htrans_out,
    input  logic [DATA_W-1:0]   ms_riscv32_mp_data_in,
    input  logic                ms_riscv32_mp_data_hready_in,
    input  logic                ms_riscv32_mp_hresp_in
);
    localparam int MW = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_last;
    logic              r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [MW-1:0]     r_mask;
    logic              r_rsp0_v;
    logic              r_rsp1_v;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              r_err0;
    logic              r_err1;
    logic              w_sel;
    logic              w_accept;
    logic              w_done;
    logic              w_tmo;
    logic              w_rst_n;

    assign w_rst_n  = ms_riscv32_mp_rst_in;
    assign w_accept = w_rst_n && (r_state == S_IDLE)
                      && (req0_valid_in || req1_valid_in);
    assign w_done   = (r_state == S_DATA) && ms_riscv32_mp_data_hready_in;

    // Round-robin pick: on a tie the port that did not win last time
    always_comb begin
        w_sel = req1_valid_in;
        if (req0_valid_in && req1_valid_in)
            w_sel = ~r_last;
    end

`ifdef MSRV32_DARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] r_tmo_cnt;

    assign w_tmo = (r_state == S_DATA) && !ms_riscv32_mp_data_hready_in
                   && (r_tmo_cnt == TMO_LAST);

    // Count data-phase wait states, restarting on every data phase entry
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!w_rst_n)
            r_tmo_cnt <= '0;
        else if (r_state == S_ADDR && ms_riscv32_mp_data_hready_in)
            r_tmo_cnt <= '0;
        else if (r_state == S_DATA && !ms_riscv32_mp_data_hready_in)
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
`else
    // Timeout disabled: data phase waits on hready forever
    assign w_tmo = (TIMEOUT_CYCLES < 0);
`endif

    // State register
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!w_rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept) w_next = S_ADDR;
            S_ADDR: if (ms_riscv32_mp_data_hready_in) w_next = S_DATA;
            S_DATA: if (w_done || w_tmo) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        req0_ready_out                = w_accept && !w_sel;
        req1_ready_out                = w_accept && w_sel;
        ms_riscv32_mp_data_htrans_out = (r_state == S_ADDR) ? 2'b10 : 2'b00;
        ms_riscv32_mp_dmaddr_out      = r_addr;
        ms_riscv32_mp_dmdata_out      = r_wdata;
        ms_riscv32_mp_dmwr_mask_out   = r_mask;
        ms_riscv32_mp_dmwr_req_out    = r_we;
        rsp0_valid_out                = r_rsp0_v;
        rsp0_rdata_out                = r_rdata0;
        rsp0_err_out                  = r_err0;
        rsp1_valid_out                = r_rsp1_v;
        rsp1_rdata_out                = r_rdata1;
        rsp1_err_out                  = r_err1;
    end

    // Capture the winning request and remember who won
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!w_rst_n) begin
            r_last  <= 1'b1;
            r_owner <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_mask  <= '0;
        end else if (w_accept) begin
            r_last  <= w_sel;
            r_owner <= w_sel;
            r_we    <= w_sel ? req1_we_in    : req0_we_in;
            r_addr  <= w_sel ? req1_addr_in  : req0_addr_in;
            r_wdata <= w_sel ? req1_wdata_in : req0_wdata_in;
            r_mask  <= w_sel ? req1_wmask_in : req0_wmask_in;
        end
    end

    // Return read data / error to the owner as a one-cycle pulse
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!w_rst_n) begin
            r_rsp0_v <= 1'b0;
            r_rsp1_v <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_err0   <= 1'b0;
            r_err1   <= 1'b0;
        end else begin
            r_rsp0_v <= 1'b0;
            r_rsp1_v <= 1'b0;
            if (w_done || w_tmo) begin
                if (r_owner) begin
                    r_rsp1_v <= 1'b1;
                    r_rdata1 <= (r_we || w_tmo) ? '0 : ms_riscv32_mp_data_in;
                    r_err1   <= w_tmo | ms_riscv32_mp_hresp_in;
                end else begin
                    r_rsp0_v <= 1'b1;
                    r_rdata0 <= (r_we || w_tmo) ? '0 : ms_riscv32_mp_data_in;
                    r_err0   <= w_tmo | ms_riscv32_mp_hresp_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_msrv32_ahb_data_arbiter.sv
// Bench for msrv32_ahb_data_arbiter: transaction model + directed cases.
// Honours MSRV32_DARB_TIMEOUT_EN the same way the design does.
module tb_msrv32_ahb_data_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        v0 = 0, v1 = 0, we0 = 0, we1 = 0;
    logic [31:0] a0 = 0, a1 = 0, wd0 = 0, wd1 = 0;
    logic [3:0]  m0 = 0, m1 = 0;
    logic        hready = 1'b1, hresp = 1'b0;
    logic [31:0] din = 0;
    logic        r0, r1, rv0, rv1, e0, e1, wr;
    logic [31:0] rd0, rd1, daddr, ddata;
    logic [3:0]  dmask;
    logic [1:0]  htrans;

    int nvec = 0;
    int nerr = 0;

    msrv32_ahb_data_arbiter dut (
        .ms_riscv32_mp_clk_in(clk),
        .ms_riscv32_mp_rst_in(rst),
        .req0_valid_in(v0), .req0_addr_in(a0), .req0_wdata_in(wd0),
        .req0_wmask_in(m0), .req0_we_in(we0), .req0_ready_out(r0),
        .rsp0_valid_out(rv0), .rsp0_rdata_out(rd0), .rsp0_err_out(e0),
        .req1_valid_in(v1), .req1_addr_in(a1), .req1_wdata_in(wd1),
        .req1_wmask_in(m1), .req1_we_in(we1), .req1_ready_out(r1),
        .rsp1_valid_out(rv1), .rsp1_rdata_out(rd1), .rsp1_err_out(e1),
        .ms_riscv32_mp_dmaddr_out(daddr),
        .ms_riscv32_mp_dmdata_out(ddata),
        .ms_riscv32_mp_dmwr_mask_out(dmask),
        .ms_riscv32_mp_dmwr_req_out(wr),
        .ms_riscv32_mp_data_htrans_out(htrans),
        .ms_riscv32_mp_data_in(din),
        .ms_riscv32_mp_data_hready_in(hready),
        .ms_riscv32_mp_hresp_in(hresp)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding transfer
    bit        m_busy = 0, m_adone = 0, m_last = 1, m_own = 0, m_we = 0;
    bit [31:0] m_addr = 0, m_wd = 0;
    bit [3:0]  m_mask = 0;
    bit [1:0]  m_rsp = 0;
    bit [31:0] m_rdata [2] = '{0, 0};
    bit        m_err [2] = '{0, 0};
    int        m_wait = 0;

    function automatic bit pick(bit p0, bit p1, bit last);
        return (p0 && p1) ? !last : p1;
    endfunction

    always @(negedge clk) begin
        cmp("ready0", r0,
            rst && !m_busy && v0 && (!v1 || m_last));
        cmp("ready1", r1,
            rst && !m_busy && v1 && (!v0 || !m_last));
        cmp("htrans", htrans, (m_busy && !m_adone) ? 2 : 0);
        if (m_busy && !m_adone) begin
            cmp("addr", daddr, m_addr);
            cmp("we", wr, m_we);
            cmp("mask", dmask, m_mask);
        end
        if (m_busy && m_adone)
            cmp("wdata", ddata, m_wd);
        cmp("rsp0_v", rv0, m_rsp[0]);
        cmp("rsp1_v", rv1, m_rsp[1]);
        cmp("rdata0", rd0, m_rdata[0]);
        cmp("rdata1", rd1, m_rdata[1]);
        cmp("err0", e0, m_err[0]);
        cmp("err1", e1, m_err[1]);
        if (!rst) begin
            m_busy <= 0; m_adone <= 0; m_last <= 1; m_rsp <= 0;
            m_rdata <= '{0, 0}; m_err <= '{0, 0};
        end else begin
            m_rsp <= 0;
            if (!m_busy) begin
                if (v0 || v1) begin
                    m_own  <= pick(v0, v1, m_last);
                    m_last <= pick(v0, v1, m_last);
                    m_addr <= pick(v0, v1, m_last) ? a1 : a0;
                    m_wd   <= pick(v0, v1, m_last) ? wd1 : wd0;
                    m_mask <= pick(v0, v1, m_last) ? m1 : m0;
                    m_we   <= pick(v0, v1, m_last) ? we1 : we0;
                    m_busy <= 1; m_adone <= 0;
                end
            end else if (!m_adone) begin
                if (hready) begin
                    m_adone <= 1; m_wait <= 0;
                end
            end else if (hready) begin
                m_rsp[m_own]   <= 1'b1;
                m_rdata[m_own] <= m_we ? 32'h0 : din;
                m_err[m_own]   <= hresp;
                m_busy <= 0;
            end
`ifdef MSRV32_DARB_TIMEOUT_EN
            else if (m_wait == 15) begin
                m_rsp[m_own]   <= 1'b1;
                m_rdata[m_own] <= 32'h0;
                m_err[m_own]   <= 1'b1;
                m_busy <= 0;
            end else begin
                m_wait <= m_wait + 1;
            end
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 0; cyc(); cyc(); rst = 1;
    endtask

    task automatic drain();
        v0 = 0; v1 = 0; hready = 1; hresp = 0;
        repeat (5) cyc();
    endtask

    int gq[$];
    int rq[$];

    initial begin
        #1;
        cyc(); cyc();
        #2;
        cmp("rst_htrans", htrans, 0);
        cmp("rst_addr", daddr, 0);
        cmp("rst_rsp0", rv0, 0);
        cyc();
        rst = 1;
        // 1: single read, zero wait
        v0 = 1; we0 = 0; a0 = 32'h100; hready = 1; din = 32'hDEADBEEF;
        #2 cmp("t1_ready0", r0, 1);
        cyc(); v0 = 0;
        #2 cmp("t1_htrans", htrans, 2);
        cmp("t1_addr", daddr, 32'h100);
        cyc();
        #2 cmp("t1_dphase", htrans, 0);
        cyc();
        #2 cmp("t1_rsp0_v", rv0, 1);
        cmp("t1_rdata", rd0, 32'hDEADBEEF);
        cmp("t1_err", e0, 0);
        cmp("t1_rsp1_v", rv1, 0);
        drain();
        // 2: both held from reset -> 0,1,0,1
        do_reset();
        v0 = 1; v1 = 1; we0 = 0; we1 = 0; hready = 1;
        for (int i = 0; i < 12; i++) begin
            #2;
            if (r0) gq.push_back(0);
            if (r1) gq.push_back(1);
            if (rv0) rq.push_back(0);
            if (rv1) rq.push_back(1);
            cyc();
        end
        cmp("t2_ngrants", gq.size(), 4);
        cmp("t2_nrsp", rq.size(), 3);
        for (int i = 0; i < gq.size(); i++)
            cmp("t2_grant", gq[i], i % 2);
        for (int i = 0; i < rq.size(); i++)
            cmp("t2_rsp_owner", rq[i], gq[i]);
        drain();
        // 3: write on port 1 with 3 data wait states
        v1 = 1; we1 = 1; a1 = 32'h200; wd1 = 32'h12345678; m1 = 4'b0011;
        #2 cmp("t3_ready1", r1, 1);
        cyc(); v1 = 0; wd1 = 0; m1 = 0;
        #2 cmp("t3_we", wr, 1);
        cmp("t3_mask_a", dmask, 4'b0011);
        cyc(); hready = 0;
        for (int i = 0; i < 3; i++) begin
            #2 cmp("t3_wdata", ddata, 32'h12345678);
            cmp("t3_mask", dmask, 4'b0011);
            cmp("t3_rsp_early", rv1, 0);
            cyc();
        end
        hready = 1; din = 32'hFFFFFFFF;
        #2 cmp("t3_wdata_last", ddata, 32'h12345678);
        cyc();
        #2 cmp("t3_rsp1_v", rv1, 1);
        cmp("t3_rdata", rd1, 0);
        drain();
        // 4: read with bus error
        v0 = 1; we0 = 0; a0 = 32'h500;
        cyc(); v0 = 0;
        cyc(); hresp = 1; din = 32'h55;
        cyc(); hresp = 0;
        #2 cmp("t4_rsp0_v", rv0, 1);
        cmp("t4_err", e0, 1);
        drain();
        // 5: reset during data phase
        v0 = 1; we0 = 1; a0 = 32'h300; wd0 = 32'hA5A5A5A5; m0 = 4'hF;
        cyc(); v0 = 0;
        cyc(); hready = 0; rst = 0;
        cyc(); rst = 1;
        #2 cmp("t5_htrans", htrans, 0);
        cmp("t5_addr", daddr, 0);
        cmp("t5_wdata", ddata, 0);
        cmp("t5_wr", {wr, dmask}, 0);
        cmp("t5_rsp", {rv0, rv1, e0, e1}, 0);
        cmp("t5_rdata", {rd0, rd1}, 0);
        cyc(); hready = 1; v0 = 1; we0 = 0;
        #2 cmp("t5_idle", r0, 1);
        cmp("t5_norsp", rv0, 0);
        drain();
        // 6: long data-phase stall
        v0 = 1; we0 = 0; a0 = 32'h400;
        cyc(); v0 = 0;
        cyc(); hready = 0;
`ifdef MSRV32_DARB_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            #2 cmp("t6_wait", rv0, 0);
            cyc();
        end
        #2 cmp("t6_tmo_v", rv0, 1);
        cmp("t6_tmo_err", e0, 1);
        cmp("t6_tmo_rdata", rd0, 0);
`else
        for (int i = 0; i < 20; i++) begin
            #2 cmp("t6_wait", rv0, 0);
            cyc();
        end
        hready = 1; din = 32'hCAFE0001;
        cyc();
        #2 cmp("t6_rsp0_v", rv0, 1);
        cmp("t6_rdata", rd0, 32'hCAFE0001);
`endif
        drain();
        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            v0 = ($urandom_range(0, 3) != 0);
            v1 = ($urandom_range(0, 2) != 0);
            a0 = $urandom; a1 = $urandom;
            wd0 = $urandom; wd1 = $urandom;
            m0 = 4'($urandom); m1 = 4'($urandom);
            we0 = 1'($urandom); we1 = 1'($urandom);
            hready = ($urandom_range(0, 3) != 0);
            hresp = ($urandom_range(0, 7) == 0);
            din = $urandom;
            rst = ($urandom_range(0, 199) != 0);
            cyc();
        end
        rst = 1;
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
